// File: rtl/dm_access_pkg.sv
// -----------------------------------------------------------------------------
// dm_access_pkg
// Shared definitions for the data-memory access unit:
//   - request size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL)
//   - the access FSM state enum (IDLE, READ, WRITE, RESP, ERR)
//   - f_misaligned(): alignment check for a size / byte-offset pair
// Build option: DM_ACCESS_SUBWORD_EN (used by the importing modules).
// -----------------------------------------------------------------------------
package dm_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } state_t;

    // A halfword must sit on an even byte, a word on a 4-byte boundary.
    // Bytes are always aligned; the illegal size is reported separately.
    function automatic logic f_misaligned(input logic [1:0] size,
                                          input logic [1:0] offset);
        logic result;
        result = 1'b0;
        case (size)
            SZ_HALF: result = offset[0];
            SZ_WORD: result = (offset != 2'b00);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dm_lane_mux.sv
// -----------------------------------------------------------------------------
// dm_lane_mux
// Purely combinational little-endian byte-lane logic.
//   Store merge : replaces the addressed byte/half lane (or the whole word)
//                 of i_old_word with the low bits of i_new_data -> o_merged.
//   Load extract: selects the addressed lane of i_old_word and zero- or
//                 sign-extends it to 32 bits -> o_result.
// Ports:
//   i_old_word  [31:0] word previously read from memory
//   i_new_data  [31:0] right-justified store data
//   i_size      [1:0]  access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   i_offset    [1:0]  byte offset inside the word
//   i_signed           sign-extend loads when 1
//   o_merged    [31:0] word to write back
//   o_result    [31:0] aligned, extended load result
// Only instantiated when DM_ACCESS_SUBWORD_EN is defined.
// -----------------------------------------------------------------------------
module dm_lane_mux
    import dm_access_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_new_data,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_signed,
    output logic [31:0] o_merged,
    output logic [31:0] o_result
);

    // Store merge: each output byte lane decides whether it is overwritten
    // and, if so, which byte of the right-justified store data feeds it.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       w_sel;
            logic [7:0] w_src;

            always_comb begin
                w_sel = 1'b0;
                w_src = i_new_data[8*gi +: 8];
                case (i_size)
                    SZ_BYTE: begin
                        w_sel = (i_offset == LANE);
                        w_src = i_new_data[7:0];
                    end
                    SZ_HALF: begin
                        w_sel = (i_offset[1] == LANE[1]);
                        w_src = i_new_data[8*(gi % 2) +: 8];
                    end
                    SZ_WORD: begin
                        w_sel = 1'b1;
                        w_src = i_new_data[8*gi +: 8];
                    end
                    default: begin
                        w_sel = 1'b0;
                        w_src = i_new_data[8*gi +: 8];
                    end
                endcase
            end

            assign o_merged[8*gi +: 8] = w_sel ? w_src : i_old_word[8*gi +: 8];
        end
    endgenerate

    // Load extract
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_old_word[7:0];
        case (i_offset)
            2'd0:    w_byte = i_old_word[7:0];
            2'd1:    w_byte = i_old_word[15:8];
            2'd2:    w_byte = i_old_word[23:16];
            default: w_byte = i_old_word[31:24];
        endcase
    end

    assign w_half = i_offset[1] ? i_old_word[31:16] : i_old_word[15:0];

    always_comb begin
        o_result = i_old_word;
        case (i_size)
            SZ_BYTE: o_result = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_result = {{16{i_signed & w_half[15]}}, w_half};
            default: o_result = i_old_word;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// -----------------------------------------------------------------------------
// dm_access_unit
// Multi-cycle load/store initiator between the CPU datapath and a
// word-organised 4 KiB data memory with a combinational read port.
// One request at a time over valid/ready; sub-word stores are done as a
// read-modify-write; load data is lane-aligned and extended.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake
//   req_we              1 = store, 0 = load
//   req_size  [1:0]     00 byte, 01 half, 10 word, 11 illegal
//   req_signed          sign-extend loads
//   req_addr  [31:0]    byte address (only the low ADDR_W bits decoded)
//   req_wdata [31:0]    right-justified store data
//   resp_valid          one-cycle completion pulse
//   resp_err            misaligned / illegal request
//   resp_rdata [31:0]   load result, 0 for stores and errors
//   mem_we              memory write enable
//   mem_addr  [9:0]     word address
//   mem_din   [31:0]    memory write data
//   mem_dout  [31:0]    memory combinational read data
//
// Build option DM_ACCESS_SUBWORD_EN:
//   defined   - byte/half accesses supported, sub-word stores use READ first.
//   undefined - only word accesses are legal; everything else goes to ERR,
//               stores go straight to WRITE, no lane logic.
// -----------------------------------------------------------------------------
module dm_access_unit
    import dm_access_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    state_t              r_state;
    state_t              w_state_next;

    logic                r_we;
    logic [1:0]          r_size;
    logic                r_signed;
    logic [1:0]          r_off;
    logic [ADDR_W-3:0]   r_waddr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_data;

    logic                w_accept;
    logic                w_req_err;
    logic                w_need_read;
    logic [31:0]         w_merged;
    logic [31:0]         w_result;

    // Address bits above the decoded range are deliberately ignored.
    logic                w_unused_addr;
    assign w_unused_addr = &{1'b0, req_addr[31:ADDR_W], 1'b0};

    assign w_accept = req_valid && (r_state == IDLE);

`ifdef DM_ACCESS_SUBWORD_EN
    assign w_req_err   = (req_size == SZ_ILL) || f_misaligned(req_size, req_addr[1:0]);
    // Loads always read; sub-word stores read first so the other lanes survive.
    assign w_need_read = !req_we || (req_size != SZ_WORD);

    dm_lane_mux u_lane_mux (
        .i_old_word (r_data),
        .i_new_data (r_wdata),
        .i_size     (r_size),
        .i_offset   (r_off),
        .i_signed   (r_signed),
        .o_merged   (w_merged),
        .o_result   (w_result)
    );
`else
    assign w_req_err   = (req_size != SZ_WORD) || f_misaligned(req_size, req_addr[1:0]);
    assign w_need_read = !req_we;
    assign w_merged    = r_wdata;
    assign w_result    = r_data;

    // Lane controls are captured but have no consumer in the word-only build.
    logic w_unused_lane;
    assign w_unused_lane = &{1'b0, r_size, r_signed, r_off, 1'b0};
`endif

    // State and request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_off    <= 2'b00;
            r_waddr  <= '0;
            r_wdata  <= 32'd0;
            r_data   <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_we     <= req_we;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_off    <= req_addr[1:0];
                r_waddr  <= req_addr[ADDR_W-1:2];
                r_wdata  <= req_wdata;
            end
            if (r_state == READ) begin
                r_data <= mem_dout;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_req_err) begin
                        w_state_next = ERR;
                    end else if (w_need_read) begin
                        w_state_next = READ;
                    end else begin
                        w_state_next = WRITE;
                    end
                end
            end
            READ:    w_state_next = r_we ? WRITE : RESP;
            WRITE:   w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            ERR:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the state; rst forces every output low in
    // the same cycle, which also keeps a dropped WRITE from committing.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = 32'd0;
        if (!rst) begin
            mem_addr = r_waddr;
            mem_din  = w_merged;
            case (r_state)
                IDLE:  req_ready = 1'b1;
                WRITE: mem_we    = 1'b1;
                RESP: begin
                    resp_valid = 1'b1;
                    resp_rdata = r_we ? 32'd0 : w_result;
                end
                ERR: begin
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// -----------------------------------------------------------------------------
// tb_dm_access_unit
// Directed, table-driven bench for dm_access_unit with a behavioural 1024-word
// memory (combinational read, write on posedge). Expectations adapt to whether
// DM_ACCESS_SUBWORD_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    always #5 clk = ~clk;

    dm_access_unit #(.ADDR_W(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    // Behavioural data memory
    logic [31:0] mem [0:1023];
    logic        mem_clr;
    int          we_cnt = 0;

    assign mem_dout = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
        if (mem_we) we_cnt <= we_cnt + 1;
    end

`ifdef DM_ACCESS_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One request: drive, wait for accept, then observe the response.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic err, output logic [31:0] rd, output int lat,
                          output logic busy_ready, output int pulses);
        int we0;
        err        = 1'bx;
        rd         = 'x;
        lat        = 99;
        busy_ready = 1'bx;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        for (int k = 0; k < 10 && !req_ready; k++) @(negedge clk);
        @(posedge clk);
        we0 = we_cnt;
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) busy_ready = req_ready;
            if (resp_valid) begin
                lat = c;
                err = resp_err;
                rd  = resp_rdata;
                break;
            end
        end
        pulses = we_cnt - we0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;      // error in every build
        logic        sub;      // sub-word access (error when sub-word is disabled)
        logic [31:0] rd_sw;    // load result with sub-word support
        logic [31:0] rd_nosw;  // load result in the word-only build
        int          lat;      // response latency when not an error
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic err, input logic sub,
                                input logic [31:0] rd_sw, input logic [31:0] rd_nosw,
                                input int lat);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.err = err; v.sub = sub; v.rd_sw = rd_sw; v.rd_nosw = rd_nosw; v.lat = lat;
        return v;
    endfunction

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;
    localparam int NV = 20;
    vec_t vt [NV];

    logic        t_err;
    logic [31:0] t_rd;
    int          t_lat;
    logic        t_busy;
    int          t_pulses;

    initial begin
        //            we  sz sgn addr          wdata         err sub rd_sw         rd_nosw       lat
        vt[0]  = mk(1'b1, W, 1'b0, 32'h010,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        32'h0,        2);
        vt[1]  = mk(1'b0, W, 1'b0, 32'h010,  32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 2);
        vt[2]  = mk(1'b1, W, 1'b0, 32'h010,  32'h11223344, 1'b0, 1'b0, 32'h0,        32'h0,        2);
        vt[3]  = mk(1'b1, B, 1'b0, 32'h012,  32'h123456AA, 1'b0, 1'b1, 32'h0,        32'h0,        3);
        vt[4]  = mk(1'b0, B, 1'b1, 32'h012,  32'h0,        1'b0, 1'b1, 32'hFFFFFFAA, 32'h0,        2);
        vt[5]  = mk(1'b0, B, 1'b0, 32'h012,  32'h0,        1'b0, 1'b1, 32'h000000AA, 32'h0,        2);
        vt[6]  = mk(1'b0, W, 1'b0, 32'h010,  32'h0,        1'b0, 1'b0, 32'h11AA3344, 32'h11223344, 2);
        vt[7]  = mk(1'b0, H, 1'b0, 32'h011,  32'h0,        1'b1, 1'b1, 32'h0,        32'h0,        1);
        vt[8]  = mk(1'b0, W, 1'b0, 32'h013,  32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1);
        vt[9]  = mk(1'b0, X, 1'b0, 32'h010,  32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1);
        vt[10] = mk(1'b0, W, 1'b0, 32'h010,  32'h0,        1'b0, 1'b0, 32'h11AA3344, 32'h11223344, 2);
        vt[11] = mk(1'b1, W, 1'b0, 32'h1010, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,        32'h0,        2);
        vt[12] = mk(1'b0, W, 1'b0, 32'h010,  32'h0,        1'b0, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 2);
        vt[13] = mk(1'b1, W, 1'b0, 32'h020,  32'h12345678, 1'b0, 1'b0, 32'h0,        32'h0,        2);
        vt[14] = mk(1'b1, H, 1'b0, 32'h022,  32'hFFFFBEEF, 1'b0, 1'b1, 32'h0,        32'h0,        3);
        vt[15] = mk(1'b0, H, 1'b1, 32'h022,  32'h0,        1'b0, 1'b1, 32'hFFFFBEEF, 32'h0,        2);
        vt[16] = mk(1'b0, H, 1'b0, 32'h020,  32'h0,        1'b0, 1'b1, 32'h00005678, 32'h0,        2);
        vt[17] = mk(1'b0, B, 1'b1, 32'h021,  32'h0,        1'b0, 1'b1, 32'h00000056, 32'h0,        2);
        vt[18] = mk(1'b0, W, 1'b0, 32'h020,  32'h0,        1'b0, 1'b0, 32'hBEEF5678, 32'h12345678, 2);
        vt[19] = mk(1'b0, B, 1'b0, 32'h000,  32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        2);

        rst = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready",  {31'd0, req_ready},  32'd0);
        check("rst_rvalid", {31'd0, resp_valid}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we},     32'd0);
        check("rst_rdata",  resp_rdata,          32'd0);
        mem_clr = 1'b0;
        rst     = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        $display("txn reset: ready=%0d after release", req_ready);

        // Table-driven transactions
        for (int i = 0; i < NV; i++) begin
            logic        e_err;
            logic [31:0] e_rd;
            int          e_lat;
            e_err = vt[i].err | (vt[i].sub & !SUBWORD);
            e_rd  = e_err ? 32'd0 : (SUBWORD ? vt[i].rd_sw : vt[i].rd_nosw);
            e_lat = e_err ? 1 : vt[i].lat;
            do_req(vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr, vt[i].wdata,
                   t_err, t_rd, t_lat, t_busy, t_pulses);
            $display("txn %0d: we=%0d size=%0d addr=%08h -> lat=%0d err=%0d rdata=%08h writes=%0d",
                     i, vt[i].we, vt[i].size, vt[i].addr, t_lat, t_err, t_rd, t_pulses);
            check($sformatf("v%0d_lat", i),    t_lat, e_lat);
            check($sformatf("v%0d_err", i),    {31'd0, t_err}, {31'd0, e_err});
            check($sformatf("v%0d_rdata", i),  t_rd, e_rd);
            check($sformatf("v%0d_writes", i), t_pulses, (vt[i].we && !e_err) ? 1 : 0);
            check($sformatf("v%0d_busy", i),   {31'd0, t_busy}, 32'd0);
        end
        check("mem_word4", mem[4], 32'hCAFEF00D);
        check("mem_word8", mem[8], SUBWORD ? 32'hBEEF5678 : 32'h12345678);

        // Reset while the store sits in WRITE: it must not commit or respond.
        do_req(1'b1, W, 1'b0, 32'h030, 32'hA5A5A5A5, t_err, t_rd, t_lat, t_busy, t_pulses);
        $display("txn prefill: addr=00000030 -> lat=%0d writes=%0d", t_lat, t_pulses);
        check("prefill_lat", t_lat, 2);
        begin
            int   we0;
            int   wait_n;
            logic rv_seen;
            wait_n  = SUBWORD ? 2 : 1;
            rv_seen = 1'b0;
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_signed = 1'b0;
            req_size  = SUBWORD ? H : W;
            req_addr  = 32'h032; req_wdata = 32'h00001234;
            if (!SUBWORD) req_addr = 32'h030;
            @(posedge clk);
            we0 = we_cnt;
            #1 req_valid = 1'b0;
            for (int c = 0; c < wait_n; c++) begin
                @(negedge clk);
                rv_seen = rv_seen | resp_valid;
            end
            check("abort_in_write", {31'd0, mem_we}, 32'd1);
            rst = 1'b1;
            #1;
            check("abort_we_forced", {31'd0, mem_we}, 32'd0);
            repeat (2) begin
                @(negedge clk);
                rv_seen = rv_seen | resp_valid;
            end
            rst = 1'b0;
            @(posedge clk); #1;
            check("abort_ready", {31'd0, req_ready}, 32'd1);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                rv_seen = rv_seen | resp_valid;
            end
            check("abort_no_resp", {31'd0, rv_seen}, 32'd0);
            check("abort_writes", we_cnt - we0, 0);
            check("abort_mem", mem[12], 32'hA5A5A5A5);
            $display("txn abort: resp_seen=%0d writes=%0d mem=%08h", rv_seen, we_cnt - we0, mem[12]);
        end

        // Recovery after the abort
        do_req(1'b0, W, 1'b0, 32'h030, 32'h0, t_err, t_rd, t_lat, t_busy, t_pulses);
        $display("txn recover: addr=00000030 -> lat=%0d err=%0d rdata=%08h", t_lat, t_err, t_rd);
        check("recover_lat", t_lat, 2);
        check("recover_rdata", t_rd, 32'hA5A5A5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

Multi-cycle initiator that sits between the CPU datapath and the word-organised 4 KiB data memory. It accepts one byte, halfword or word load/store request at a time over a valid/ready handshake. Sub-word stores become a read-modify-write, and load data is aligned and extended. It drives the memory's write-enable, word address and write data, and samples its combinational read port.

## Interface
Parameters:
- ADDR_W, 12: byte-address bits decoded; bits above are ignored, so addresses wrap modulo 4 KiB.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_signed  in  1  loads: sign-extend when 1, zero-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid; misaligned or illegal request.
- resp_rdata  out  32  aligned and extended load data; 0 for stores and errors.
- mem_we  out  1  memory write enable.
- mem_addr  out  10  word address, equal to req_addr[11:2].
- mem_din  out  32  memory write data.
- mem_dout  in  32  memory combinational read data.

## Operation
- Byte lanes are little-endian, and the lane is selected by addr[1:0].
- A request is accepted on a cycle where req_valid and req_ready are both high. All request fields are registered at that edge and held internally until the response.
- The request is an error when either condition holds:
  - the halfword address has addr[0] set, or the word address has addr[1:0] != 0;
  - size is 11.
  An error request makes no memory access.
- FSM states:
  - IDLE: req_ready=1. On accept, go to ERR if the request is an error. Otherwise go to READ for loads and sub-word stores, and to WRITE for word stores.
  - READ: mem_addr is driven and mem_dout is captured into a data register. Loads then go to RESP; sub-word stores go to WRITE.
  - WRITE: mem_we=1. mem_din is req_wdata for a word store, or the captured word with the selected byte/half lane replaced by the low bits of req_wdata. Then go to RESP.
  - RESP: resp_valid=1, resp_err=0. Then go to IDLE.
  - ERR: resp_valid=1, resp_err=1. Then go to IDLE.
- Load result: select the lane from the captured word, then extend it to 32 bits per req_signed.
- mem_we is high only in WRITE. mem_addr and mem_din hold their last values otherwise; mem_din is don't-care when mem_we=0.
- There is no response back-pressure. The requester must take resp_valid in the cycle it pulses.

## Timing
- Let the accept edge be T0. Responses pulse in the following cycle after T0:
  - load: T2.
  - word store: T2; the memory is written at the T1→T2 edge.
  - sub-word store: T3; the memory is written at the T2→T3 edge.
  - error: T1.
- req_ready is low from T0 through the response cycle. A new request can be accepted in the cycle after resp_valid.
- Back-to-back word loads sustain one load per 3 cycles.
- Reset takes effect at any state. The FSM goes to IDLE and all outputs go to 0 while rst=1; this includes req_ready. An in-flight request is dropped with no response.
- A dropped store that was already in WRITE when rst rose does not commit, because mem_we is forced to 0 during reset.
- After rst falls, req_ready=1 in the first cycle.

## Configuration
- DM_ACCESS_SUBWORD_EN defined:
  - byte and halfword accesses are supported as above;
  - the READ-before-WRITE path for stores exists.
- Not defined:
  - only size 10 is legal; 00, 01 and 11 are error requests and go to ERR;
  - stores never visit READ;
  - the lane-merge and extend logic is removed, and resp_rdata is the captured word.

## Structure
- dm_access_pkg holds:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the FSM state enum: IDLE, READ, WRITE, RESP, ERR;
  - the misalignment-check function.
- One combinational sub-module, dm_lane_mux, does two things:
  - store merge: old word, new data, size, offset → merged word;
  - load extract: word, size, offset, signed → result.
  It is instantiated only under DM_ACCESS_SUBWORD_EN.

## Test plan
- Word store 0xDEADBEEF to 0x010, then a word load of 0x010 → mem_we pulses once, resp_valid appears at T2 for each request, and resp_rdata=0xDEADBEEF.
- With word 0x010=0x11223344:
  - byte store 0xAA at 0x012 → word becomes 0x11AA3344, with resp_valid at T3;
  - signed byte load at 0x012 → 0xFFFFFFAA;
  - unsigned byte load at 0x012 → 0x000000AA.
- Half load at 0x011, and word load at 0x013 → resp_err=1 at T1; mem_we never asserts and memory is unchanged.
- Store to 0x1010 → lands at word address 0x004; bits above bit 11 are ignored.
- Assert rst during the WRITE state of a half store → memory is unchanged, no resp_valid, and req_ready=1 the cycle after rst falls.
- With DM_ACCESS_SUBWORD_EN undefined, a byte load at 0x000 → resp_err=1 at T1.
